// File: rtl/trg_seq_pkg.sv
// ---------------------------------------------------------------------------
// trg_seq_pkg
// Shared definitions for the trigger sequencer: group count, timing units,
// the sequencer state encoding and a helper that converts the dead-time
// setting (10 us units) into a clock count.
// ---------------------------------------------------------------------------
package trg_seq_pkg;

    localparam int unsigned NUM_GRP        = 5;
    localparam int unsigned DEAD_UNIT_CLKS = 500;   // 10 us at 50 MHz
    localparam int unsigned STRETCH_CLKS   = 50;    // 1 us at 50 MHz
    localparam int unsigned DIV_W          = 6;
    localparam int unsigned DEAD_CNT_W     = 17;    // holds 255 * 500

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_FIRE   = 2'd2,
        S_DEAD   = 2'd3
    } seq_state_t;

    function automatic logic [DEAD_CNT_W-1:0] dead_clks(input logic [7:0] units);
        return DEAD_CNT_W'(units) * DEAD_CNT_W'(DEAD_UNIT_CLKS);
    endfunction

endpackage

// File: rtl/grp_prescaler.sv
// ---------------------------------------------------------------------------
// grp_prescaler
// Prescaler for one logic group. Each i_step advances the counter; the step
// passes when the counter equals div-1, after which the counter clears.
// A divide setting of 0 or 1 passes every step.
// With TRG_SEQ_CNT_EN defined, a saturating 16-bit count of passed steps is
// also kept.
//
// Ports:
//   i_clk   - system clock
//   i_srst  - synchronous active-high reset
//   i_step  - advance this prescaler (one cycle)
//   i_div   - divide ratio
//   o_pass  - combinational: this step passes the prescaler
//   o_cnt   - (TRG_SEQ_CNT_EN only) saturating count of passed steps
// ---------------------------------------------------------------------------
module grp_prescaler
    import trg_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_step,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_pass
`ifdef TRG_SEQ_CNT_EN
    ,
    output logic [15:0]      o_cnt
`endif
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (i_div <= DIV_W'(1)) || (r_cnt == (i_div - DIV_W'(1)));
    assign o_pass = i_step & w_hit;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= w_hit ? '0 : (r_cnt + DIV_W'(1));
        end
    end

`ifdef TRG_SEQ_CNT_EN
    logic [15:0] r_pass_cnt;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_pass_cnt <= '0;
        end else if (o_pass && (r_pass_cnt != 16'hFFFF)) begin
            r_pass_cnt <= r_pass_cnt + 16'd1;
        end
    end

    assign o_cnt = r_pass_cnt;
`endif

endmodule

// File: rtl/trg_sequencer.sv
// ---------------------------------------------------------------------------
// trg_sequencer
// Collects rising edges of the enabled group match levels over a window,
// applies per-group prescaling, issues a one-cycle trigger with the tag of
// the groups that passed, then holds off for a programmable dead time.
//
// Optional feature macro: TRG_SEQ_CNT_EN adds grp_cnt_out, a saturating
// 16-bit per-group count of passed triggers.
//
// Ports:
//   clk_in        - 50 MHz system clock
//   rst_in        - synchronous active-high reset
//   grp_match_in  - per-group coincidence match level
//   grp_oe_in     - per-group enable
//   grp_div_in    - 6-bit prescale per group, group g at [6g+5:6g]
//   busy_in       - detector busy; blocks start and aborts the window
//   match_win_in  - collection window length in clocks
//   dead_time_in  - dead time in 10 us units
//   trg_out       - one-cycle trigger pulse
//   tag_out       - groups that fired, held until next trigger
//   trg_1us_out   - trg_out stretched to 50 clocks
//   seq_busy_out  - sequencer not idle
//   grp_cnt_out   - (TRG_SEQ_CNT_EN only) 16 bits per group passed counts
// ---------------------------------------------------------------------------
module trg_sequencer
    import trg_seq_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_GRP-1:0]       grp_match_in,
    input  logic [NUM_GRP-1:0]       grp_oe_in,
    input  logic [DIV_W*NUM_GRP-1:0] grp_div_in,
    input  logic                     busy_in,
    input  logic [7:0]               match_win_in,
    input  logic [7:0]               dead_time_in,
    output logic                     trg_out,
    output logic [NUM_GRP-1:0]       tag_out,
    output logic                     trg_1us_out,
    output logic                     seq_busy_out
`ifdef TRG_SEQ_CNT_EN
    ,
    output logic [16*NUM_GRP-1:0]    grp_cnt_out
`endif
);

    localparam logic [5:0] STRETCH_LOAD = 6'(STRETCH_CLKS);

    seq_state_t              r_state;
    seq_state_t              w_state_next;
    logic [NUM_GRP-1:0]      r_prev;
    logic [NUM_GRP-1:0]      r_evt;
    logic [NUM_GRP-1:0]      r_raw;
    logic [7:0]              r_win_cnt;
    logic [DEAD_CNT_W-1:0]   r_dead_cnt;
    logic                    r_trg;
    logic [NUM_GRP-1:0]      r_tag;
    logic [5:0]              r_str_cnt;

    logic [NUM_GRP-1:0]      w_cur;
    logic [NUM_GRP-1:0]      w_edge;
    logic [NUM_GRP-1:0]      w_pass;
    logic                    w_fire;
    logic                    w_accept;
    logic                    w_trg_next;

    assign w_cur  = grp_match_in & grp_oe_in;
    assign w_edge = w_cur & ~r_prev;
    assign w_fire = (r_state == S_FIRE);

    // Prescalers only advance in FIRE, so an aborted window leaves them alone.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_GRP; gi++) begin : g_presc
            grp_prescaler u_presc (
                .i_clk  (clk_in),
                .i_srst (rst_in),
                .i_step (w_fire & r_raw[gi]),
                .i_div  (grp_div_in[DIV_W*gi +: DIV_W]),
                .o_pass (w_pass[gi])
`ifdef TRG_SEQ_CNT_EN
                ,
                .o_cnt  (grp_cnt_out[16*gi +: 16])
`endif
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_trg_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_evt != '0) && !busy_in) begin
                    w_accept     = 1'b1;
                    w_state_next = (match_win_in == 8'd0) ? S_FIRE : S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (busy_in) begin
                    w_state_next = S_IDLE;
                end else if (r_win_cnt <= 8'd1) begin
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                if (w_pass != '0) begin
                    w_trg_next   = 1'b1;
                    w_state_next = S_DEAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DEAD: begin
                if (r_dead_cnt == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_evt      <= '0;
            r_raw      <= '0;
            r_win_cnt  <= '0;
            r_dead_cnt <= '0;
            r_trg      <= 1'b0;
            r_tag      <= '0;
            r_str_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_prev  <= w_cur;
            // Edges seen while in DEAD are dropped here, so they can never
            // start a sequence once the sequencer returns to IDLE.
            r_evt   <= (r_state == S_DEAD) ? '0 : w_edge;
            r_trg   <= w_trg_next;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_raw     <= r_evt;
                        r_win_cnt <= match_win_in;
                    end
                end
                S_WINDOW: begin
                    if (!busy_in) begin
                        r_raw     <= r_raw | r_evt;
                        r_win_cnt <= r_win_cnt - 8'd1;
                    end
                end
                S_DEAD: begin
                    if (r_dead_cnt != '0) begin
                        r_dead_cnt <= r_dead_cnt - DEAD_CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_trg_next) begin
                r_tag      <= w_pass;
                r_dead_cnt <= dead_clks(dead_time_in);
                r_str_cnt  <= STRETCH_LOAD;
            end else if (r_str_cnt != 6'd0) begin
                r_str_cnt  <= r_str_cnt - 6'd1;
            end
        end
    end

    assign trg_out      = r_trg;
    assign tag_out      = r_tag;
    assign trg_1us_out  = (r_str_cnt != 6'd0);
    assign seq_busy_out = (r_state != S_IDLE);

endmodule

// File: tb/tb_trg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trg_sequencer
// Self-checking bench for trg_sequencer. A timestamp-based reference model
// predicts every output each cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_trg_sequencer;

    logic        clk_in       = 1'b0;
    logic        rst_in       = 1'b1;
    logic [4:0]  grp_match_in = '0;
    logic [4:0]  grp_oe_in    = '0;
    logic [29:0] grp_div_in   = '0;
    logic        busy_in      = 1'b0;
    logic [7:0]  match_win_in = '0;
    logic [7:0]  dead_time_in = '0;
    logic        trg_out;
    logic [4:0]  tag_out;
    logic        trg_1us_out;
    logic        seq_busy_out;
`ifdef TRG_SEQ_CNT_EN
    logic [79:0] grp_cnt_out;
`endif

    trg_sequencer dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .grp_match_in (grp_match_in),
        .grp_oe_in    (grp_oe_in),
        .grp_div_in   (grp_div_in),
        .busy_in      (busy_in),
        .match_win_in (match_win_in),
        .dead_time_in (dead_time_in),
        .trg_out      (trg_out),
        .tag_out      (tag_out),
        .trg_1us_out  (trg_1us_out),
        .seq_busy_out (seq_busy_out)
`ifdef TRG_SEQ_CNT_EN
        ,
        .grp_cnt_out  (grp_cnt_out)
`endif
    );

    always #10 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_trg   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------
    // Reference model. A sequence is described by timestamps: the edge it
    // was accepted, the last edge of its collection window, the decision
    // edge and the edge at which the hold-off ends.
    // -----------------------------------------------------------------
    logic [4:0] m_prev, m_evt, m_raw, exp_tag;
    bit         m_active, m_dead, exp_trg;
    int         m_win_last, m_fire_at, m_dead_until, exp_str;
    int         pc[5];
    int         gcnt[5];

    always @(posedge clk_in) begin
        logic [4:0] cur, edge_now, ev, passed;
        bit         in_dead, fired;
        int         d;
        cyc++;
        if (rst_in) begin
            m_prev = '0; m_evt = '0; m_raw = '0; exp_tag = '0;
            m_active = 0; m_dead = 0; exp_trg = 0; exp_str = 0;
            for (int g = 0; g < 5; g++) begin pc[g] = 0; gcnt[g] = 0; end
            chk_en = 1'b1;
        end else begin
            cur      = grp_match_in & grp_oe_in;
            edge_now = cur & ~m_prev;
            m_prev   = cur;
            ev       = m_evt;
            in_dead  = m_active && m_dead;
            m_evt    = in_dead ? 5'd0 : edge_now;
            fired    = 0;
            exp_trg  = 0;
            if (!m_active) begin
                if (ev != 0 && !busy_in) begin
                    m_active   = 1;
                    m_dead     = 0;
                    m_raw      = ev;
                    m_win_last = cyc + int'(match_win_in);
                    m_fire_at  = m_win_last + 1;
                end
            end else if (!m_dead) begin
                if (cyc <= m_win_last) begin
                    if (busy_in) m_active = 0;
                    else m_raw |= ev;
                end else begin
                    passed = '0;
                    for (int g = 0; g < 5; g++) begin
                        if (m_raw[g]) begin
                            d = int'(grp_div_in[6*g +: 6]);
                            if (d <= 1 || pc[g] == d - 1) begin
                                passed[g] = 1'b1;
                                pc[g] = 0;
                                if (gcnt[g] < 65535) gcnt[g]++;
                            end else begin
                                pc[g] = (pc[g] + 1) % 64;
                            end
                        end
                    end
                    if (passed != 0) begin
                        fired        = 1;
                        exp_trg      = 1;
                        exp_tag      = passed;
                        m_dead       = 1;
                        m_dead_until = cyc + int'(dead_time_in) * 500 + 1;
                    end else begin
                        m_active = 0;
                    end
                end
            end else if (cyc == m_dead_until) begin
                m_active = 0;
            end
            if (fired) exp_str = 50;
            else if (exp_str > 0) exp_str--;
        end
    end

    // Compare process: registered outputs are stable at the falling edge.
    always @(negedge clk_in) begin
        if (trg_out === 1'b1) begin
            n_trg++;
            $display("[TB] trigger cycle=%0d tag=%b", cyc, tag_out);
        end
        if (chk_en) begin
            chk("trg_out", trg_out, exp_trg);
            chk("tag_out", tag_out, exp_tag);
            chk("trg_1us_out", trg_1us_out, exp_str > 0);
            chk("seq_busy_out", seq_busy_out, m_active);
`ifdef TRG_SEQ_CNT_EN
            for (int g = 0; g < 5; g++)
                chk("grp_cnt_out", grp_cnt_out[16*g +: 16], gcnt[g]);
`endif
        end
    end

    // -----------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1; grp_match_in = '0; busy_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic setup(input logic [29:0] div, input logic [7:0] win, input logic [7:0] dead);
        grp_div_in = div; match_win_in = win; dead_time_in = dead; grp_oe_in = 5'h1F;
        do_reset();
    endtask

    task automatic pulse(input logic [4:0] bits);
        grp_match_in = bits;
        @(negedge clk_in);
        grp_match_in = '0;
    endtask

    localparam logic [29:0] DIV_ALL1 = {5{6'd1}};

    initial begin
        int c0, t_trg, t_idle, base;
        bit seen;

        // Single event: latency, tag and busy span measured from the sampling edge.
        setup(DIV_ALL1, 8'd0, 8'd1);
        chk("reset_busy", seq_busy_out, 0);
        chk("reset_trg", trg_out, 0);
        c0 = cyc;
        grp_match_in = 5'b00001;
        @(negedge clk_in);
        grp_match_in = '0;
        t_trg = -1; t_idle = -1; seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_in);
            if (trg_out && t_trg < 0) t_trg = cyc - (c0 + 1);
            if (seq_busy_out) seen = 1;
            else if (seen && t_idle < 0) t_idle = cyc - (c0 + 1);
        end
        chk("single_latency", t_trg, 2);
        chk("single_tag", tag_out, 5'b00001);
        chk("single_busy_span", t_idle, 503);
        $display("[TB] single event: latency=%0d busy_span=%0d", t_trg, t_idle);

        // Two groups inside one 5-clock window.
        setup(DIV_ALL1, 8'd5, 8'd0);
        base = n_trg;
        grp_match_in = 5'b00001;
        wait_cyc(3);
        grp_match_in = 5'b01001;
        wait_cyc(1);
        grp_match_in = '0;
        wait_cyc(20);
        chk("window_count", n_trg - base, 1);
        chk("window_tag", tag_out, 5'b01001);
        $display("[TB] window merge: tag=%b", tag_out);

        // Group 1 divided by 2: triggers on the 2nd and 4th edges only.
        setup({6'd1, 6'd1, 6'd1, 6'd2, 6'd1}, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            base = n_trg;
            pulse(5'b00010);
            wait_cyc(10);
            chk("prescale_edge", n_trg - base, (i % 2 == 1) ? 1 : 0);
            $display("[TB] prescale edge %0d: triggers=%0d", i + 1, n_trg - base);
        end

        // busy_in during WINDOW aborts; the next edge triggers normally.
        setup(DIV_ALL1, 8'd8, 8'd0);
        base = n_trg;
        pulse(5'b00100);
        wait_cyc(2);
        busy_in = 1'b1;
        wait_cyc(1);
        busy_in = 1'b0;
        wait_cyc(15);
        chk("abort_no_trg", n_trg - base, 0);
        chk("abort_idle", seq_busy_out, 0);
        pulse(5'b00100);
        wait_cyc(15);
        chk("after_abort_trg", n_trg - base, 1);
        chk("after_abort_tag", tag_out, 5'b00100);
        $display("[TB] busy abort: triggers=%0d", n_trg - base);

        // Edges during DEAD and a held level do not retrigger.
        setup(DIV_ALL1, 8'd0, 8'd1);
        base = n_trg;
        grp_match_in = 5'b10000;
        wait_cyc(20);
        chk("dead_first", n_trg - base, 1);
        for (int i = 0; i < 40; i++) begin
            grp_match_in[0] = ~grp_match_in[0];
            wait_cyc(1);
        end
        grp_match_in[0] = 1'b0;
        wait_cyc(520);
        chk("dead_no_retrig", n_trg - base, 1);
        chk("dead_idle", seq_busy_out, 0);
        grp_match_in = '0;
        wait_cyc(2);
        grp_match_in = 5'b10000;
        wait_cyc(10);
        chk("dead_fresh_edge", n_trg - base, 2);
        grp_match_in = '0;
        wait_cyc(510);
        $display("[TB] dead discard: triggers=%0d", n_trg - base);

        // Reset pulsed mid-DEAD clears everything.
        setup(DIV_ALL1, 8'd0, 8'd2);
        pulse(5'b00001);
        wait_cyc(100);
        chk("pre_reset_busy", seq_busy_out, 1);
        rst_in = 1'b1;
        wait_cyc(1);
        rst_in = 1'b0;
        chk("mid_dead_reset", {trg_out, tag_out, trg_1us_out, seq_busy_out}, 0);
`ifdef TRG_SEQ_CNT_EN
        chk("mid_dead_reset_cnt", (grp_cnt_out == '0) ? 1 : 0, 1);
`endif
        $display("[TB] mid-dead reset done");

        // Randomised scenarios against the reference model.
        for (int s = 0; s < 20; s++) begin
            logic [29:0] div;
            for (int g = 0; g < 5; g++) div[6*g +: 6] = 6'($urandom_range(0, 4));
            setup(div, 8'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0);
            grp_oe_in = 5'h1F & ~5'($urandom_range(0, 31) & $urandom_range(0, 31));
            $display("[TB] random scenario %0d div=%h win=%0d dead=%0d oe=%b",
                     s, div, match_win_in, dead_time_in, grp_oe_in);
            for (int c = 0; c < 300; c++) begin
                for (int g = 0; g < 5; g++)
                    if ($urandom_range(0, 5) == 0) grp_match_in[g] = ~grp_match_in[g];
                busy_in = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 99) == 0) match_win_in = 8'($urandom_range(0, 6));
                wait_cyc(1);
            end
            busy_in = 1'b0;
            grp_match_in = '0;
        end

        wait_cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
